// File: rtl/pc_fetch_stage.sv
// pc_fetch_stage
//   Instruction-fetch stage. This block holds the architectural PC and drives
//   the instruction-ROM address from it. It registers the fetched instruction
//   into the IF/ID pipeline register.
//
//   Priority on each rising edge is redirect > stall > advance. A redirect
//   loads a word-aligned target and inserts one nop bubble into IF/ID. It also
//   flags a misaligned target with a one-cycle misalign_err pulse.
//
//   Optional feature (macro PERF_CNT_EN): adds two 32-bit performance
//   counters.
//
// Parameters
//   RESET_PC         PC value loaded on reset
//
// Ports
//   clk              clock, all state on rising edge
//   rst_n            asynchronous active-low reset
//   stall            hold PC and IF/ID
//   redirect         taken jump/branch from EX; wins over stall
//   redirect_target  target from the next-PC unit
//   inst_rdata       combinational IROM data for inst_addr
//   inst_addr        IROM address (= pc)
//   pc               current fetch PC
//   if_id_pc         PC of the instruction in IF/ID
//   if_id_pc4        if_id_pc + 4
//   if_id_inst       instruction in IF/ID
//   if_id_valid      IF/ID holds a real instruction (0 = bubble)
//   misalign_err     one-cycle pulse when redirect_target[1:0] != 0
//   perf_fetch_cnt   (PERF_CNT_EN) edges that loaded a valid instruction
//   perf_bubble_cnt  (PERF_CNT_EN) edges that loaded a redirect bubble
module pc_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic [31:0] inst_rdata,
  output logic [31:0] inst_addr,
  output logic [31:0] pc,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_inst,
  output logic        if_id_valid,
  output logic        misalign_err
`ifdef PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt
`endif
);

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic [31:0] pc_plus4;
  logic        advance;

  assign pc_plus4  = pc + 32'd4;
  assign advance   = !redirect && !stall;
  // IROM address comes straight from the PC register, so stall and redirect
  // never reach it combinationally.
  assign inst_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      if_id_pc     <= '0;
      if_id_pc4    <= '0;
      if_id_inst   <= '0;
      if_id_valid  <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= 1'b0;
      if (redirect) begin
        // The branch in EX is older than any stalled op, so redirect ignores stall.
        pc           <= {redirect_target[31:2], 2'b00};
        if_id_pc     <= '0;
        if_id_pc4    <= '0;
        if_id_inst   <= NOP_INST;
        if_id_valid  <= 1'b0;
        misalign_err <= |redirect_target[1:0];
      end else if (advance) begin
        pc           <= pc_plus4;
        if_id_pc     <= pc;
        if_id_pc4    <= pc_plus4;
        if_id_inst   <= inst_rdata;
        if_id_valid  <= 1'b1;
      end
    end
  end

`ifdef PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt  <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (redirect) begin
        perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      end else if (advance) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
